// File: rtl/mem_seq.sv
// Memory access sequencer: turns single read/write strobes into a timed RAM access
// with a done pulse. It rejects misaligned or malformed requests without touching RAM.
module mem_seq #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [15:0]       acc_cnt,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait
        $fatal(1, "mem_seq: WAIT_CYC must be in 0..15");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              we_q, we_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0]       acc_cnt_q, acc_cnt_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        acc_cnt_d = acc_cnt_q;
        case (state_q)
            IDLE: begin
                if ((req_rd && req_wr) || ((req_rd || req_wr) && addr[1:0] != 2'b00)) begin
                    state_d = ERR;
                end else if (req_rd || req_wr) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_CYC);
                    wr_d    = req_wr;
                    we_d    = req_wr;  // write strobe only in the first ACCESS cycle
                    addr_d  = addr[ADDR_W-1:2];
                    wdata_d = wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (!wr_q) rdata_d = ram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                acc_cnt_d = acc_cnt_q + 16'd1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            acc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == RESP);
    assign err       = (state_q == ERR);
    assign ram_en    = (state_q == ACCESS);
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign acc_cnt   = acc_cnt_q;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: three instances (WAIT_CYC 2, 0, 3), each with a small RAM model.
module tb_mem_seq;

    localparam int WCS [3] = '{2, 0, 3};

    logic        clk = 1'b0;
    logic        rst     [3];
    logic        req_rd  [3];
    logic        req_wr  [3];
    logic [31:0] addr    [3];
    logic [31:0] wdata   [3];
    logic        ready   [3];
    logic        done    [3];
    logic [31:0] rdata   [3];
    logic        err     [3];
    logic [15:0] acc_cnt [3];
    logic        ram_en  [3];
    logic        ram_we  [3];
    logic [29:0] ram_addr  [3];
    logic [31:0] ram_wdata [3];
    logic [31:0] ram_rdata [3];
    logic        bd_we   [3];
    logic [5:0]  bd_addr [3];
    logic [31:0] bd_data [3];

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_u
        logic [31:0] mem [0:63];

        mem_seq #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(WCS[g])) u (
            .clk(clk), .reset(rst[g]), .req_rd(req_rd[g]), .req_wr(req_wr[g]),
            .addr(addr[g]), .wdata(wdata[g]), .ready(ready[g]), .done(done[g]),
            .rdata(rdata[g]), .err(err[g]), .acc_cnt(acc_cnt[g]), .ram_en(ram_en[g]),
            .ram_we(ram_we[g]), .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]),
            .ram_rdata(ram_rdata[g])
        );

        // Backdoor port preloads words; otherwise only the DUT writes the array.
        always @(posedge clk) begin
            if (bd_we[g]) mem[bd_addr[g]] <= bd_data[g];
            else if (ram_en[g] && ram_we[g]) mem[ram_addr[g][5:0]] <= ram_wdata[g];
        end
        assign ram_rdata[g] = ram_en[g] ? mem[ram_addr[g][5:0]] : 32'h0;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int k, input logic [5:0] a, input logic [31:0] d);
        bd_we[k] = 1'b1; bd_addr[k] = a; bd_data[k] = d;
        tick();
        bd_we[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_rd[k] = 1'b0; req_wr[k] = 1'b0;
            addr[k] = '0; wdata[k] = '0; bd_we[k] = 1'b0; bd_addr[k] = '0; bd_data[k] = '0;
        end
        @(negedge clk);
        tick(); tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        chk("rst_ready", ready[0], 1);
        chk("rst_done", done[0], 0);
        chk("rst_err", err[0], 0);
        chk("rst_ram_en", ram_en[0], 0);
        chk("rst_ram_we", ram_we[0], 0);
        chk("rst_rdata", rdata[0], 0);
        chk("rst_acc_cnt", acc_cnt[0], 0);
        chk("rst_ram_addr", ram_addr[0], 0);

        // Read, WAIT_CYC=2
        preload(0, 6'h10, 32'hDEADBEEF);
        req_rd[0] = 1'b1; addr[0] = 32'h40;
        tick();
        chk("rd_t1_en", ram_en[0], 1);
        chk("rd_t1_addr", ram_addr[0], 32'h10);
        chk("rd_t1_ready", ready[0], 0);
        chk("rd_t1_we", ram_we[0], 0);
        tick();
        chk("rd_t2_en", ram_en[0], 1);
        chk("rd_t2_addr", ram_addr[0], 32'h10);
        tick();
        chk("rd_t3_en", ram_en[0], 1);
        chk("rd_t3_done", done[0], 0);
        tick();
        chk("rd_t4_done", done[0], 1);
        chk("rd_t4_rdata", rdata[0], 32'hDEADBEEF);
        chk("rd_t4_en", ram_en[0], 0);
        req_rd[0] = 1'b0;
        tick();
        chk("rd_t5_ready", ready[0], 1);
        chk("rd_t5_done", done[0], 0);
        chk("rd_t5_acc", acc_cnt[0], 1);

        // Write, WAIT_CYC=0, then read back
        req_wr[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'h12345678;
        tick();
        chk("wr_t1_we", ram_we[1], 1);
        chk("wr_t1_en", ram_en[1], 1);
        chk("wr_t1_addr", ram_addr[1], 2);
        chk("wr_t1_wdata", ram_wdata[1], 32'h12345678);
        tick();
        chk("wr_t2_done", done[1], 1);
        chk("wr_t2_we", ram_we[1], 0);
        req_wr[1] = 1'b0;
        tick();
        chk("wr_t3_ready", ready[1], 1);
        chk("wr_t3_we", ram_we[1], 0);
        req_rd[1] = 1'b1;
        tick();
        chk("wrrd_t1_we", ram_we[1], 0);
        tick();
        chk("wrrd_t2_done", done[1], 1);
        chk("wrrd_t2_rdata", rdata[1], 32'h12345678);
        req_rd[1] = 1'b0;
        tick();
        chk("wrrd_acc", acc_cnt[1], 2);

        // Misaligned, then both strobes
        req_rd[0] = 1'b1; addr[0] = 32'h41;
        tick();
        chk("mis_err", err[0], 1);
        chk("mis_en", ram_en[0], 0);
        chk("mis_ready", ready[0], 0);
        req_rd[0] = 1'b0;
        tick();
        chk("mis_ready2", ready[0], 1);
        chk("mis_err2", err[0], 0);
        chk("mis_en2", ram_en[0], 0);
        req_rd[0] = 1'b1; req_wr[0] = 1'b1; addr[0] = 32'h44;
        tick();
        chk("both_err", err[0], 1);
        chk("both_en", ram_en[0], 0);
        chk("both_we", ram_we[0], 0);
        req_rd[0] = 1'b0; req_wr[0] = 1'b0;
        tick();
        chk("both_ready", ready[0], 1);
        chk("both_acc", acc_cnt[0], 1);
        chk("both_rdata", rdata[0], 32'hDEADBEEF);

        // Back-pressure: address changes while the access is in flight
        preload(0, 6'h11, 32'hA5A50001);
        preload(0, 6'h12, 32'hA5A50002);
        req_rd[0] = 1'b1; addr[0] = 32'h44;
        tick();
        addr[0] = 32'h48;
        chk("bp_t1_addr", ram_addr[0], 32'h11);
        tick();
        addr[0] = 32'h03;
        chk("bp_t2_addr", ram_addr[0], 32'h11);
        tick();
        chk("bp_t3_addr", ram_addr[0], 32'h11);
        chk("bp_t3_err", err[0], 0);
        tick();
        chk("bp_done", done[0], 1);
        chk("bp_rdata", rdata[0], 32'hA5A50001);
        req_rd[0] = 1'b0;
        tick();
        chk("bp_done_once", done[0], 0);
        chk("bp_ready", ready[0], 1);
        tick();
        chk("bp_idle_done", done[0], 0);
        chk("bp_acc", acc_cnt[0], 2);

        // Reset mid-ACCESS, WAIT_CYC=3
        preload(2, 6'h05, 32'hCAFE0005);
        req_rd[2] = 1'b1; addr[2] = 32'h14;
        tick(); tick(); tick(); tick();
        chk("r3_pre_done", done[2], 0);
        tick();
        chk("r3_done", done[2], 1);
        chk("r3_rdata", rdata[2], 32'hCAFE0005);
        req_rd[2] = 1'b0;
        tick();
        chk("r3_acc", acc_cnt[2], 1);
        req_wr[2] = 1'b1; addr[2] = 32'h18; wdata[2] = 32'h77;
        tick();
        chk("r3w_we", ram_we[2], 1);
        tick();
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0; req_wr[2] = 1'b0;
        chk("mrst_ready", ready[2], 1);
        chk("mrst_done", done[2], 0);
        chk("mrst_err", err[2], 0);
        chk("mrst_en", ram_en[2], 0);
        chk("mrst_we", ram_we[2], 0);
        chk("mrst_rdata", rdata[2], 0);
        chk("mrst_acc", acc_cnt[2], 0);
        chk("mrst_addr", ram_addr[2], 0);
        chk("mrst_wdata", ram_wdata[2], 0);
        req_rd[2] = 1'b1; addr[2] = 32'h14;
        tick(); tick(); tick(); tick(); tick();
        chk("post_done", done[2], 1);
        chk("post_rdata", rdata[2], 32'hCAFE0005);
        req_rd[2] = 1'b0;
        tick();
        chk("post_acc", acc_cnt[2], 1);

        // Counter wrap: jump the idle counter near the top instead of 65534 reads
        force g_u[1].u.acc_cnt_q = 16'hFFFE;
        tick();
        release g_u[1].u.acc_cnt_q;
        tick();
        chk("wrap_pre", acc_cnt[1], 32'hFFFE);
        addr[1] = 32'h8;
        for (int n = 0; n < 2; n++) begin
            req_rd[1] = 1'b1;
            tick(); tick();
            chk("wrap_done", done[1], 1);
            req_rd[1] = 1'b0;
            tick();
            chk(n == 0 ? "wrap_ffff" : "wrap_zero", acc_cnt[1], n == 0 ? 32'hFFFF : 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
